// File: rtl/led_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : led_seq_pkg
// Description : Shared definitions for the LED sequence controller family.
//               Pattern mode encodings, controller FSM states and the
//               pattern each mode starts from (pattern bit 1 = LED lit).
// Revision    : 1.0 - initial release
// ============================================================================
package led_seq_pkg;

    typedef enum logic [1:0] {
        MODE_SHL    = 2'd0,
        MODE_SHR    = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_BLINK  = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [3:0] c_INIT_SHL    = 4'b0001;
    localparam logic [3:0] c_INIT_SHR    = 4'b1000;
    localparam logic [3:0] c_INIT_BOUNCE = 4'b0001;
    localparam logic [3:0] c_INIT_BLINK  = 4'b1111;
    localparam logic [3:0] c_PAT_OFF     = 4'b0000;

    function automatic logic [3:0] init_pattern(input mode_t mode);
        logic [3:0] pat;
        case (mode)
            MODE_SHL:    pat = c_INIT_SHL;
            MODE_SHR:    pat = c_INIT_SHR;
            MODE_BOUNCE: pat = c_INIT_BOUNCE;
            MODE_BLINK:  pat = c_INIT_BLINK;
            default:     pat = c_PAT_OFF;
        endcase
        return pat;
    endfunction

endpackage
`default_nettype wire

// File: rtl/led_step_timer.sv
`default_nettype none
// ============================================================================
// Module      : led_step_timer
// Description : Step interval counter. While enabled it counts 0..period and
//               wraps, raising tick for the cycle in which the count equals
//               period, so a tick occurs every period+1 enabled cycles.
// Ports       : sys_clk, sys_rst (sync, active high)
//               clear  - force count to 0 (dominates enable)
//               enable - count this cycle
//               period - interval minus one
//               tick   - one-cycle pulse on the wrap edge
// Revision    : 1.0 - initial release
// ============================================================================
module led_step_timer #(
    parameter int PERIOD_W = 25
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic                clear,
    input  logic                enable,
    input  logic [PERIOD_W-1:0] period,
    output logic                tick
);

    logic [PERIOD_W-1:0] r_count;
    logic                w_wrap;

    assign w_wrap = (r_count == period);
    // Tick is decoded from the registered count so the consumer can act on
    // the very edge where the count wraps.
    assign tick   = enable && !clear && w_wrap;

    always_ff @(posedge sys_clk) begin
        if (sys_rst || clear) begin
            r_count <= '0;
        end else if (enable) begin
            if (w_wrap) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/led_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : led_seq_ctrl
// Description : LED sequence controller. Accepts a command (mode, step count,
//               step period) in IDLE, advances a 4-bit pattern every
//               period+1 cycles in RUN, pulses done for one cycle after the
//               last step, then returns to IDLE holding the final pattern.
// Ports       : sys_clk, sys_rst (sync, active high)
//               cmd_valid/cmd_ready, cmd_mode, cmd_steps (0 = endless),
//               cmd_period (interval minus one), stop (abort RUN)
//               led_out (active low), busy, done
// Revision    : 1.0 - initial release
// ============================================================================
module led_seq_ctrl
    import led_seq_pkg::*;
#(
    parameter int PERIOD_W = 25,
    parameter int STEPS_W  = 8
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_mode,
    input  logic [STEPS_W-1:0]  cmd_steps,
    input  logic [PERIOD_W-1:0] cmd_period,
    input  logic                stop,
    output logic [3:0]          led_out,
    output logic                busy,
    output logic                done
);

    state_t              r_state;
    mode_t               r_mode;
    logic [STEPS_W-1:0]  r_steps;
    logic [STEPS_W-1:0]  r_remain;
    logic [PERIOD_W-1:0] r_period;
    logic                r_dir_up;
    logic [3:0]          r_led_n;
    logic                r_ready;
    logic                r_busy;
    logic                r_done;

    logic [3:0]          w_pattern;
    logic [3:0]          w_next_pattern;
    logic                w_next_dir;
    logic                w_tick;
    logic                w_running;

    // The pattern is held inverted so the LED drive comes straight off flops.
    assign w_pattern = ~r_led_n;
    assign w_running = (r_state == ST_RUN);

    led_step_timer #(
        .PERIOD_W (PERIOD_W)
    ) u_timer (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .clear   (!w_running),
        .enable  (w_running),
        .period  (r_period),
        .tick    (w_tick)
    );

    always_comb begin
        w_next_pattern = w_pattern;
        w_next_dir     = r_dir_up;
        case (r_mode)
            MODE_SHL:    w_next_pattern = {w_pattern[2:0], w_pattern[3]};
            MODE_SHR:    w_next_pattern = {w_pattern[0], w_pattern[3:1]};
            MODE_BOUNCE: begin
                // Reverse at either end: the end LED is shown once, then
                // the next step already moves back inward.
                if (r_dir_up) begin
                    if (w_pattern[3]) begin
                        w_next_pattern = {1'b0, w_pattern[3:1]};
                        w_next_dir     = 1'b0;
                    end else begin
                        w_next_pattern = {w_pattern[2:0], 1'b0};
                    end
                end else begin
                    if (w_pattern[0]) begin
                        w_next_pattern = {w_pattern[2:0], 1'b0};
                        w_next_dir     = 1'b1;
                    end else begin
                        w_next_pattern = {1'b0, w_pattern[3:1]};
                    end
                end
            end
            MODE_BLINK:  w_next_pattern = ~w_pattern;
            default:     w_next_pattern = w_pattern;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state  <= ST_IDLE;
            r_mode   <= MODE_SHL;
            r_steps  <= '0;
            r_remain <= '0;
            r_period <= '0;
            r_dir_up <= 1'b1;
            r_led_n  <= ~c_PAT_OFF;
            r_ready  <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // stop alone is meaningless here; a command always wins.
                    if (cmd_valid) begin
                        r_mode   <= mode_t'(cmd_mode);
                        r_steps  <= cmd_steps;
                        r_remain <= cmd_steps;
                        r_period <= cmd_period;
                        r_dir_up <= 1'b1;
                        r_led_n  <= ~init_pattern(mode_t'(cmd_mode));
                        r_state  <= ST_RUN;
                        r_ready  <= 1'b0;
                        r_busy   <= 1'b1;
                    end
                end
                ST_RUN: begin
                    // Abort beats a coincident final step: no advance, no done.
                    if (stop) begin
                        r_state <= ST_IDLE;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                    end else if (w_tick) begin
                        r_led_n  <= ~w_next_pattern;
                        r_dir_up <= w_next_dir;
                        // A zero step count means run forever: never count down.
                        if (r_steps != '0) begin
                            r_remain <= r_remain - 1'b1;
                            if (r_remain == STEPS_W'(1)) begin
                                r_state <= ST_DONE;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign led_out   = r_led_n;
    assign cmd_ready = r_ready;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_led_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_seq_ctrl
// Description : Self-checking bench for led_seq_ctrl. A reference model
//               derives the pattern from the number of elapsed steps, and
//               every cycle's outputs are compared against it; directed
//               scenarios add literal expectations on the LED sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_seq_ctrl;

    localparam int PERIOD_W = 25;
    localparam int STEPS_W  = 8;

    logic                sys_clk    = 1'b0;
    logic                sys_rst    = 1'b1;
    logic                cmd_valid  = 1'b0;
    logic [1:0]          cmd_mode   = '0;
    logic [STEPS_W-1:0]  cmd_steps  = '0;
    logic [PERIOD_W-1:0] cmd_period = '0;
    logic                stop       = 1'b0;
    logic                cmd_ready;
    logic [3:0]          led_out;
    logic                busy;
    logic                done;

    led_seq_ctrl #(
        .PERIOD_W (PERIOD_W),
        .STEPS_W  (STEPS_W)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_mode   (cmd_mode),
        .cmd_steps  (cmd_steps),
        .cmd_period (cmd_period),
        .stop       (stop),
        .led_out    (led_out),
        .busy       (busy),
        .done       (done)
    );

    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: pattern is a pure function of mode and the number
    // of completed steps; steps happen every (period+1) cycles of RUN.
    // ------------------------------------------------------------------
    function automatic logic [3:0] pat_of(input int mode, input int n);
        logic [3:0] tbl [0:5];
        tbl = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2};
        case (mode)
            0:       return 4'b0001 << (n % 4);
            1:       return 4'b1000 >> (n % 4);
            2:       return tbl[n % 6];
            default: return ((n % 2) == 0) ? 4'hF : 4'h0;
        endcase
    endfunction

    int         m_phase = 0;   // 0 idle, 1 running, 2 done pulse
    logic [3:0] m_pat   = '0;
    int         m_mode, m_steps, m_period, m_k, m_adv;
    bit         m_armed = 1'b0;

    always @(posedge sys_clk) begin
        if (sys_rst) begin
            m_phase = 0;
            m_pat   = '0;
            m_armed = 1'b1;
        end else begin
            case (m_phase)
                0: if (cmd_valid) begin
                    m_mode   = int'(cmd_mode);
                    m_steps  = int'(cmd_steps);
                    m_period = int'(cmd_period);
                    m_k      = 0;
                    m_adv    = 0;
                    m_pat    = pat_of(m_mode, 0);
                    m_phase  = 1;
                end
                1: if (stop) begin
                    m_phase = 0;
                end else begin
                    m_k++;
                    if ((m_k % (m_period + 1)) == 0) begin
                        m_adv++;
                        m_pat = pat_of(m_mode, m_adv);
                        if (m_steps != 0 && m_adv == m_steps) m_phase = 2;
                    end
                end
                default: m_phase = 0;
            endcase
        end
    end

    // Per-cycle comparison plus a record of LED changes for literal checks.
    logic [3:0] q_led [$];
    logic [3:0] last_led = 4'hF;
    int         done_cnt = 0;
    int         busy_cnt = 0;

    always @(posedge sys_clk) begin
        logic [3:0] e_led;
        #1;
        if (m_armed) begin
            e_led = ~m_pat;
            chk("led_out",   led_out,   e_led);
            chk("cmd_ready", cmd_ready, m_phase == 0);
            chk("busy",      busy,      m_phase == 1);
            chk("done",      done,      m_phase == 2);
        end
        if (led_out !== last_led) begin
            q_led.push_back(led_out);
            last_led = led_out;
        end
        if (done) done_cnt++;
        if (busy) busy_cnt++;
    end

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    logic [3:0] exp_q [$];

    task automatic clr_mon();
        q_led.delete();
        done_cnt = 0;
        busy_cnt = 0;
    endtask

    task automatic chk_seq(input string name);
        int n;
        chk({name, "_len"}, q_led.size(), exp_q.size());
        n = (q_led.size() < exp_q.size()) ? q_led.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk(name, q_led[i], exp_q[i]);
    endtask

    task automatic send(input int mode, input int steps, input int period);
        @(negedge sys_clk);
        cmd_valid  = 1'b1;
        cmd_mode   = mode[1:0];
        cmd_steps  = steps[STEPS_W-1:0];
        cmd_period = period[PERIOD_W-1:0];
        @(negedge sys_clk);
        cmd_valid  = 1'b0;
    endtask

    initial begin
        logic [3:0] v_all_off;
        logic [3:0] v_all_on;
        bit         accepted;
        v_all_off = 4'hF;
        v_all_on  = 4'h0;

        // Reset state
        repeat (2) @(negedge sys_clk);
        chk("rst_led",   led_out,   v_all_off);
        chk("rst_ready", cmd_ready, 1'b1);
        chk("rst_busy",  busy,      1'b0);
        chk("rst_done",  done,      1'b0);
        sys_rst = 1'b0;

        // Shift-left, 5 steps, period 3
        clr_mon();
        send(0, 5, 3);
        repeat (24) @(negedge sys_clk);
        exp_q = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110, 4'b1101};
        chk_seq("s1_seq");
        chk("s1_done_cnt", done_cnt, 1);
        chk("s1_busy_cnt", busy_cnt, 20);

        // Bounce, 8 steps, period 0
        clr_mon();
        send(2, 8, 0);
        repeat (12) @(negedge sys_clk);
        exp_q = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1011,
                  4'b1101, 4'b1110, 4'b1101, 4'b1011};
        chk_seq("s2_seq");
        chk("s2_busy_cnt", busy_cnt, 8);
        chk("s2_done_cnt", done_cnt, 1);

        // Blink endless, period 1, stop while the interval count is 1
        clr_mon();
        send(3, 0, 1);
        repeat (5) @(negedge sys_clk);
        stop = 1'b1;
        @(negedge sys_clk);
        stop = 1'b0;
        chk("s3_led_stop", led_out,   v_all_on);
        chk("s3_ready",    cmd_ready, 1'b1);
        repeat (5) @(negedge sys_clk);
        chk("s3_led_frozen", led_out, v_all_on);
        chk("s3_done_cnt",   done_cnt, 0);
        exp_q = '{4'b0000, 4'b1111, 4'b0000};
        chk_seq("s3_seq");

        // Command while busy is dropped; a held command waits for ready
        clr_mon();
        send(1, 3, 1);
        repeat (2) @(negedge sys_clk);
        cmd_valid = 1'b1; cmd_mode = 2'd0; cmd_steps = 8'd1; cmd_period = '0;
        @(negedge sys_clk);
        cmd_valid = 1'b0;
        @(negedge sys_clk);
        cmd_valid = 1'b1; cmd_mode = 2'd0; cmd_steps = 8'd2; cmd_period = '0;
        accepted = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge sys_clk);
            if (done_cnt >= 1 && busy) begin
                accepted = 1'b1;
                break;
            end
        end
        cmd_valid = 1'b0;
        chk("s4_accept", accepted, 1'b1);
        repeat (6) @(negedge sys_clk);
        chk("s4_done_cnt", done_cnt, 2);
        exp_q = '{4'b0111, 4'b1011, 4'b1101, 4'b1110, 4'b1101, 4'b1011};
        chk_seq("s4_seq");

        // Reset in the middle of a run, then a fresh command
        clr_mon();
        send(0, 10, 2);
        repeat (5) @(negedge sys_clk);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        sys_rst = 1'b0;
        chk("s5_led",   led_out,   v_all_off);
        chk("s5_busy",  busy,      1'b0);
        chk("s5_done",  done,      1'b0);
        chk("s5_ready", cmd_ready, 1'b1);
        clr_mon();
        send(0, 2, 0);
        repeat (5) @(negedge sys_clk);
        exp_q = '{4'b1110, 4'b1101, 4'b1011};
        chk_seq("s5_seq");
        chk("s5_done_cnt", done_cnt, 1);

        // cmd_valid and stop together in IDLE: command wins
        clr_mon();
        @(negedge sys_clk);
        cmd_valid = 1'b1; stop = 1'b1;
        cmd_mode = 2'd1; cmd_steps = 8'd2; cmd_period = '0;
        @(negedge sys_clk);
        cmd_valid = 1'b0; stop = 1'b0;
        repeat (5) @(negedge sys_clk);
        exp_q = '{4'b0111, 4'b1011, 4'b1101};
        chk_seq("s6_seq");
        chk("s6_done_cnt", done_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
